mips_cpu_muldiv_seq: RTL and testbench

MIPS_CPU_MULDIV_SEQ -- requirements
Module: mips_cpu_muldiv_seq

---
 rtl/mips_cpu_muldiv_seq.sv | 188 ++++++++++++++++++
 tb/tb_mips_cpu_muldiv_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv_seq.sv
// MIPS Hi/Lo multiply/divide unit.
// Signed and unsigned multiply and divide run as 32 radix-2 iterations on
// operand magnitudes, followed by one sign-fix cycle. MTHI/MTLO write Hi/Lo
// directly. Define MIPS_CPU_MULDIV_FAST_MUL_EN to compute multiplies in a
// single cycle, skipping the iterative phase.
module mips_cpu_muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        abort,
  input  logic        hilo_rd,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;      // multiply: {partial, multiplier}; divide: {remainder, quotient}
  logic [31:0] dsr_q, dsr_d;      // multiplicand or divisor magnitude
  logic [31:0] a_q, a_d;          // raw dividend, returned on divide-by-zero
  logic        is_div_q, is_div_d;
  logic        div0_q, div0_d;
  logic        neg_q_q, neg_q_d;  // negate product / quotient
  logic        neg_r_q, neg_r_d;  // negate remainder
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        sgn;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign stall = hilo_rd & busy;
  assign hi    = hi_q;
  assign lo    = lo_q;

  // Next-state, datapath iteration and Hi/Lo update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    dsr_d    = dsr_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    sgn   = (op == OP_MULT) || (op == OP_DIV);
    a_mag = (sgn && a[31]) ? -a : a;
    b_mag = (sgn && b[31]) ? -b : b;

    mul_sum = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? dsr_q : 32'd0)};
    rem_sh  = {acc_q[63:32], acc_q[31]};
    rem_ge  = (rem_sh >= {1'b0, dsr_q});
    // When rem_ge holds, the difference fits in 32 bits.
    rem_sub = rem_sh[31:0] - dsr_q;

    prod = neg_q_q ? -acc_q : acc_q;
    quo  = neg_q_q ? -acc_q[31:0] : acc_q[31:0];
    rem  = neg_r_q ? -acc_q[63:32] : acc_q[63:32];

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d = op[1];
              a_d      = a;
              div0_d   = (b == '0);
              cnt_d    = '0;
              neg_q_d  = sgn && (a[31] ^ b[31]);
              neg_r_d  = sgn && a[31];
              if (op[1]) begin
                acc_d   = {32'd0, a_mag};
                dsr_d   = b_mag;
                state_d = S_RUN;
              end else begin
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
                acc_d   = {32'd0, a_mag} * {32'd0, b_mag};
                state_d = S_FIX;
`else
                acc_d   = {32'd0, b_mag};
                dsr_d   = a_mag;
                state_d = S_RUN;
`endif
              end
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = {(rem_ge ? rem_sub : rem_sh[31:0]), acc_q[30:0], rem_ge};
          end else begin
            acc_d = {mul_sum, acc_q[31:1]};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!abort) begin
          done_d = 1'b1;
          if (is_div_q) begin
            if (div0_q) begin
              hi_d = a_q;
              lo_d = '1;
            end else begin
              hi_d = rem;
              lo_d = quo;
            end
          end else begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      dsr_q    <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      dsr_q    <= dsr_d;
      a_q      <= a_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// Self-checking bench for mips_cpu_muldiv_seq: directed corner cases plus
// randomized operations compared against an arithmetic reference model.
module tb_mips_cpu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, abort, hilo_rd;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  logic [31:0] exp_hi, exp_lo;

`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
  localparam logic [2:0] ABORT_OP = 3'd3;
`else
  localparam int MUL_LAT = 33;
  localparam logic [2:0] ABORT_OP = 3'd1;
`endif
  localparam int DIV_LAT = 33;

  mips_cpu_muldiv_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .abort   (abort),
    .hilo_rd (hilo_rd),
    .busy    (busy),
    .done    (done),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural reference: Hi/Lo after an operation, from plain arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                inout logic [31:0] h, inout logic [31:0] l);
    longint sx = $signed(x);
    longint sy = $signed(y);
    longint sp;
    logic [63:0] up;
    case (o)
      3'd0: begin sp = sx * sy; up = sp; h = up[63:32]; l = up[31:0]; end
      3'd1: begin up = {32'd0, x} * {32'd0, y}; h = up[63:32]; l = up[31:0]; end
      3'd2: begin
        if (y == 0) begin h = x; l = 32'hFFFF_FFFF; end
        else begin sp = sx / sy; l = sp[31:0]; sp = sx % sy; h = sp[31:0]; end
      end
      3'd3: begin
        if (y == 0) begin h = x; l = 32'hFFFF_FFFF; end
        else begin h = x % y; l = x / y; end
      end
      3'd4: h = x;
      3'd5: l = x;
      default: ;
    endcase
  endfunction

  // Issue one operation and check timing, stall, hold and result.
  // inj: busy cycle at which a competing start is pulsed (0 = none).
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int inj);
    logic [31:0] ph = exp_hi;
    logic [31:0] pl = exp_lo;
    int lat = (o <= 3'd1) ? MUL_LAT : DIV_LAT;
    int n = 0;
    model(o, x, y, exp_hi, exp_lo);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; a = $urandom; b = $urandom;
    if (o >= 3'd4) begin
      chk("mt_busy", busy, 0);
      chk("mt_done", done, 0);
      chk("mt_hi", hi, exp_hi);
      chk("mt_lo", lo, exp_lo);
      return;
    end
    while (!done && n < 100) begin
      chk("busy", busy, 1);
      chk("stall", stall, hilo_rd);
      chk("hi_hold", hi, ph);
      chk("lo_hold", lo, pl);
      n++;
      if (n == inj) begin start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5; end
      tick();
      start = 1'b0;
    end
    chk("done_seen", done, 1);
    chk("latency", n, lat);
    chk("hi", hi, exp_hi);
    chk("lo", lo, exp_lo);
    chk("busy_end", busy, 0);
    chk("stall_end", stall, 0);
    tick();
    chk("done_pulse", done, 0);
  endtask

  initial begin
    logic [31:0] ph, pl;
    bit any_done;
    rst = 1'b1; start = 1'b0; abort = 1'b0; hilo_rd = 1'b0; op = '0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);

    // Directed cases
    do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    chk("mult_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo, 32'hFFFF_FFFA);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_lo_const", lo, 32'hFFFF_FFFD);
    chk("div_hi_const", hi, 32'hFFFF_FFFF);
    do_op(3'd3, 32'd7, 32'd0, 0);
    chk("divu0_hi_const", hi, 32'd7);
    chk("divu0_lo_const", lo, 32'hFFFF_FFFF);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd0, 0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("divovf_lo_const", lo, 32'h8000_0000);
    chk("divovf_hi_const", hi, 32'd0);

    do_op(3'd4, 32'h1234_5678, 32'd0, 0);
    do_op(3'd5, 32'h9ABC_DEF0, 32'd0, 0);
    chk("mt_hi_const", hi, 32'h1234_5678);
    chk("mt_lo_const", lo, 32'h9ABC_DEF0);
    do_op(3'd6, 32'hDEAD_BEEF, 32'd1, 0);

    hilo_rd = 1'b1;
    do_op(3'd3, 32'd100, 32'd7, 10);
    hilo_rd = 1'b0;
    chk("divu100_hi_const", hi, 32'd2);
    chk("divu100_lo_const", lo, 32'd14);

    // Abort during the iterative phase
    ph = exp_hi; pl = exp_lo;
    start = 1'b1; op = ABORT_OP; a = '1; b = '1;
    tick(); start = 1'b0;
    repeat (19) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    any_done = 1'b0;
    repeat (40) begin tick(); any_done |= done; end
    chk("abort_no_done", any_done, 0);
    chk("abort_hi", hi, ph);
    chk("abort_lo", lo, pl);

    // Abort in the sign-fix cycle wins over completion
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
    tick(); start = 1'b0;
    repeat (32) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abortfix_busy", busy, 0);
    chk("abortfix_done", done, 0);
    chk("abortfix_hi", hi, ph);
    chk("abortfix_lo", lo, pl);

    // Abort together with start in idle: start ignored
    start = 1'b1; abort = 1'b1; op = 3'd4; a = 32'hCAFE_F00D;
    tick(); start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    chk("abort_start_hi", hi, ph);

    // Reset in the middle of a divide
    start = 1'b1; op = 3'd2; a = 32'd12345; b = 32'd17;
    tick(); start = 1'b0;
    repeat (14) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
    chk("midrst_busy", busy, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    any_done = 1'b0;
    repeat (25) begin tick(); any_done |= done; end
    chk("midrst_no_done", any_done, 0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro = 3'($urandom_range(0, 7));
      logic [31:0] rx = $urandom;
      logic [31:0] ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
      hilo_rd = 1'($urandom_range(0, 1));
      do_op(ro, rx, ry, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : 0);
    end
    hilo_rd = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
